// File: rtl/bdd_bist_pkg.sv
// ---------------------------------------------------------------------------
// bdd_bist_pkg
// Shared constants for the BDD BIST checker:
//   - FSM state encoding (IDLE, DRIVE, SAMPLE, DONE)
//   - MISR polynomial (x^8+x^6+x^5+x^4+1, Galois form) and seed value
// ---------------------------------------------------------------------------
package bdd_bist_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Feedback taps for x^6, x^5, x^4 and x^0; the x^8 term is the bit
    // shifted out of position 7.
    localparam logic [7:0] MISR_POLY = 8'h71;
    localparam logic [7:0] MISR_SEED = 8'hFF;

endpackage

// File: rtl/bdd_bist_misr.sv
// ---------------------------------------------------------------------------
// bdd_bist_misr
// 8-bit single-input signature register used by bdd_bist_checker.
// Built only when BDD_BIST_MISR_EN is defined.
// Ports:
//   clk      in  clock (rising edge)
//   rst      in  asynchronous active-high reset, clears the signature
//   seed_i   in  load MISR_SEED (has priority over shift_i)
//   shift_i  in  shift din_i into the signature this cycle
//   din_i    in  serial data bit
//   sig_o    out current signature
// ---------------------------------------------------------------------------
`ifdef BDD_BIST_MISR_EN
module bdd_bist_misr
    import bdd_bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_i,
    input  logic       shift_i,
    input  logic       din_i,
    output logic [7:0] sig_o
);

    logic [7:0] sig_q;
    logic [7:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (seed_i) begin
            sig_d = MISR_SEED;
        end else if (shift_i) begin
            // Multiply by x, reduce modulo the polynomial, add the new bit.
            sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? MISR_POLY : 8'h00) ^ {7'b0, din_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 8'h00;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule
`endif

// File: rtl/bdd_bist_checker.sv
// ---------------------------------------------------------------------------
// bdd_bist_checker
// On-chip stimulus/response checker for a small combinational function.
// Walks every input vector 0..2^N_IN-1, holds each for SETTLE cycles,
// samples dut_f and compares it against the EXPECTED truth table.
// Optional MISR signature: define BDD_BIST_MISR_EN.
// Ports:
//   clk            in   clock (rising edge)
//   rst            in   asynchronous active-high reset
//   start          in   one-cycle pulse, accepted when not busy
//   dut_in         out  vector driven to the DUT (MSB = A)
//   dut_f          in   DUT response, only looked at in SAMPLE
//   busy           out  run in progress (DRIVE or SAMPLE)
//   done           out  run finished, held until next accepted start
//   pass           out  done with zero mismatches
//   err_count      out  mismatch count, saturating
//   first_err_vec  out  first mismatching vector
//   first_err_vld  out  a mismatch was seen this run
//   signature      out  MISR signature (8'h00 without BDD_BIST_MISR_EN)
//   dbg_state      out  FSM state, for observation
// Handshake: start is a level sampled on the rising edge; it is acted on
// only in IDLE or DONE and ignored otherwise (no ready/back-pressure).
// ---------------------------------------------------------------------------
module bdd_bist_checker
    import bdd_bist_pkg::*;
#(
    parameter int                     N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'hE8,
    parameter int                     SETTLE   = 2,
    parameter int                     CNT_W    = N_IN + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_vld,
    output logic [7:0]       signature,
    output logic [1:0]       dbg_state
);

    // Settle counter only needs to hold SETTLE-1.
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE - 1);

    logic [1:0]       state_q,  state_d;
    logic [N_IN-1:0]  vec_q,    vec_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] err_q,    err_d;
    logic [N_IN-1:0]  fvec_q,   fvec_d;
    logic             fvld_q,   fvld_d;
    logic             done_q,   done_d;
    logic             busy_w;
    logic             start_acc;
    logic             mismatch;

    assign busy_w    = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign start_acc = start && !busy_w;
    assign mismatch  = dut_f ^ EXPECTED[vec_q];

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvld_d   = fvld_q;
        done_d   = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    vec_d    = '0;
                    settle_d = SETTLE_INIT;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvld_d   = 1'b0;
                    done_d   = 1'b0;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - 1'b1;
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + 1'b1;
                    end
                    if (!fvld_q) begin
                        fvec_d = vec_q;
                        fvld_d = 1'b1;
                    end
                end
                if (vec_q == '1) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    vec_d    = vec_q + 1'b1;
                    settle_d = SETTLE_INIT;
                    state_d  = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvld_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvld_q   <= fvld_d;
            done_q   <= done_d;
        end
    end

`ifdef BDD_BIST_MISR_EN
    bdd_bist_misr u_misr (
        .clk     (clk),
        .rst     (rst),
        .seed_i  (start_acc),
        .shift_i (state_q == ST_SAMPLE),
        .din_i   (dut_f),
        .sig_o   (signature)
    );
`else
    assign signature = 8'h00;
`endif

    assign dut_in        = vec_q;
    assign busy          = busy_w;
    assign done          = done_q;
    assign pass          = done_q && (err_q == '0);
    assign err_count     = err_q;
    assign first_err_vec = fvec_q;
    assign first_err_vld = fvld_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_bdd_bist_checker.sv
// ---------------------------------------------------------------------------
// tb_bdd_bist_checker
// Bench for bdd_bist_checker with default parameters. The DUT under test is
// modelled as a truth-table lookup (dut_tt). Compile with BDD_BIST_MISR_EN
// to also check the signature against a polynomial-division model.
// ---------------------------------------------------------------------------
module tb_bdd_bist_checker;

    localparam logic [7:0] GOLD = 8'hE8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] dut_in;
    logic       dut_f;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_err_vec;
    logic       first_err_vld;
    logic [7:0] signature;
    logic [1:0] dbg_state;

    logic [7:0] dut_tt;

    int n_checks;
    int n_pass;
    int hist[8];

    bdd_bist_checker dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dut_in        (dut_in),
        .dut_f         (dut_f),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_vec (first_err_vec),
        .first_err_vld (first_err_vld),
        .signature     (signature),
        .dbg_state     (dbg_state)
    );

    assign dut_f = dut_tt[dut_in];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         errs;
        logic [2:0] fvec;
        logic       fvld;
        logic       pass;
        logic [7:0] sig;
    } result_t;

    // Signature as remainder of seed*x^8 + bitstream modulo
    // x^8+x^6+x^5+x^4+1, one bit per vector in order 0..7.
    function automatic logic [7:0] ref_sig(input logic [7:0] tt);
        int s;
        s = 'hFF;
        for (int v = 0; v < 8; v++) begin
            s = (s << 1) | int'(tt[v]);
            if ((s & 'h100) != 0) s = s ^ 'h171;
        end
        return 8'(s);
    endfunction

    function automatic result_t ref_model(input logic [7:0] tt);
        result_t r;
        logic [7:0] diff;
        diff   = tt ^ GOLD;
        r.errs = $countones(diff);
        if (r.errs > 15) r.errs = 15;
        r.fvld = (diff != 8'h00);
        r.fvec = 3'd0;
        for (int v = 7; v >= 0; v--) begin
            if (diff[v]) r.fvec = 3'(v);
        end
        r.pass = (r.errs == 0);
        r.sig  = ref_sig(tt);
        return r;
    endfunction

    // ---------------- drivers ----------------
    // Pulses start so it is sampled at "edge 0", then counts edges until
    // done rises. Optional re-pulses of start at edges re1/re2.
    task automatic run_once(input logic [7:0] tt, input int re1, input int re2,
                            output int done_edge);
        dut_tt = tt;
        for (int v = 0; v < 8; v++) hist[v] = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_edge = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (busy) hist[dut_in] = hist[dut_in] + 1;
            start = (k == re1) || (k == re2);
            @(posedge clk);
            #1 start = 1'b0;
            if (done) begin
                done_edge = k;
                break;
            end
        end
        if (done_edge < 0) $display("FAIL run_timeout: done never rose within 200 cycles");
    endtask

    task automatic check_result(input string tag, input logic [7:0] tt);
        result_t r;
        r = ref_model(tt);
        chk({tag, "_done"},  done, 1'b1);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_pass"},  pass, r.pass);
        chk({tag, "_errs"},  err_count, r.errs);
        chk({tag, "_fvld"},  first_err_vld, r.fvld);
        chk({tag, "_fvec"},  first_err_vec, r.fvec);
`ifdef BDD_BIST_MISR_EN
        chk({tag, "_sig"},   signature, r.sig);
`else
        chk({tag, "_sig"},   signature, 8'h00);
`endif
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] tt;
        int         errs;
        logic [2:0] fvec;
        logic       fvld;
        logic       pass;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int         de;
        int         bad;
        logic [7:0] sig_good;
        logic [7:0] tt;

        n_checks = 0;
        n_pass   = 0;
        start    = 1'b0;
        dut_tt   = GOLD;
        rst      = 1'b1;

        tbl[0] = '{8'hE8, 0, 3'd0, 1'b0, 1'b1}; // majority
        tbl[1] = '{8'h00, 4, 3'd3, 1'b1, 1'b0}; // stuck-at-0
        tbl[2] = '{8'h17, 8, 3'd0, 1'b1, 1'b0}; // ~majority
        tbl[3] = '{8'hFF, 4, 3'd0, 1'b1, 1'b0}; // stuck-at-1
        tbl[4] = '{8'hE9, 1, 3'd0, 1'b1, 1'b0}; // wrong at vector 0 only
        tbl[5] = '{8'h68, 1, 3'd7, 1'b1, 1'b0}; // wrong at last vector only

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_errs", err_count, 4'd0);
        chk("rst_dut_in", dut_in, 3'd0);
        chk("rst_sig", signature, 8'h00);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // Scenario 1: good DUT, latency and per-vector hold time
        run_once(GOLD, -1, -1, de);
        chk("s1_done_edge", de, 24);
        bad = 0;
        for (int v = 0; v < 8; v++) if (hist[v] != 3) bad++;
        chk("s1_hold_3cyc", bad, 0);
        chk("s1_last_vec", dut_in, 3'd7);
        check_result("s1", GOLD);
        sig_good = signature;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_once(tbl[i].tt, -1, -1, de);
            chk($sformatf("tbl%0d_edge", i), de, 24);
            chk($sformatf("tbl%0d_errs", i), err_count, tbl[i].errs);
            chk($sformatf("tbl%0d_fvec", i), first_err_vec, tbl[i].fvec);
            chk($sformatf("tbl%0d_fvld", i), first_err_vld, tbl[i].fvld);
            chk($sformatf("tbl%0d_pass", i), pass, tbl[i].pass);
        end

        // Scenario 4: start while busy ignored; start in DONE clears and reruns
        run_once(GOLD, 5, 12, de);
        chk("s4_done_edge", de, 24);
        check_result("s4a", GOLD);
        run_once(8'h00, -1, -1, de);
        chk("s4_rerun_edge", de, 24);
        check_result("s4b", 8'h00);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("s4_clr_done", done, 1'b0);
        chk("s4_clr_errs", err_count, 4'd0);
        chk("s4_clr_fvld", first_err_vld, 1'b0);
        chk("s4_clr_busy", busy, 1'b1);
        de = -1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (done) begin de = k; break; end
        end
        chk("s4_clr_finished", (de >= 0), 1'b1);

        // Scenario 5: async reset mid-DRIVE at vector 4
        dut_tt = 8'h00;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bad = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy && dut_in == 3'd4 && dbg_state == 2'd1) begin bad = 0; break; end
        end
        chk("s5_reach_vec4", bad, 0);
        chk("s5_pre_errs", err_count, 4'd1);
        #1 rst = 1'b1;
        #1;
        chk("s5_busy", busy, 1'b0);
        chk("s5_done", done, 1'b0);
        chk("s5_errs", err_count, 4'd0);
        chk("s5_fvld", first_err_vld, 1'b0);
        chk("s5_fvec", first_err_vec, 3'd0);
        chk("s5_dut_in", dut_in, 3'd0);
        chk("s5_sig", signature, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        run_once(GOLD, -1, -1, de);
        chk("s5_run_edge", de, 24);
        check_result("s5", GOLD);
        chk("s5_sig_repeat", signature, sig_good);
`ifdef BDD_BIST_MISR_EN
        chk("s6_sig_nonzero", (signature != 8'h00), 1'b1);
        run_once(8'h00, -1, -1, de);
        chk("s6_sig_differs", (signature != sig_good), 1'b1);
`endif

        // Randomized DUT truth tables against the reference model
        for (int i = 0; i < 20; i++) begin
            tt = 8'($urandom_range(0, 255));
            run_once(tt, -1, -1, de);
            chk($sformatf("rnd%0d_edge", i), de, 24);
            check_result($sformatf("rnd%0d_tt%02h", i, tt), tt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
